// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the RISC-V instruction fetch front end.
package riscv_fetch_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } fetch_entry_t;

    typedef enum logic {
        RUN,
        DRAIN
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries; flush wins over push and pop.
module fetch_fifo
    import riscv_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          flush_i,
    input  logic          push_i,
    input  fetch_entry_t  push_data_i,
    input  logic          pop_i,
    output fetch_entry_t  head_o,
    output logic [CW-1:0] count_o,
    output logic          empty_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [CW-1:0] count_q, count_d;
    logic          doPush, doPop, full;

    assign empty_o = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign doPush  = push_i && !flush_i;
    assign doPop   = pop_i && !flush_i && !empty_o;
    assign head_o  = mem_q[rdPtr_q];
    assign count_o = count_q;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q + CW'(doPush) - CW'(doPop);
        if (doPush) wrPtr_d = wrPtr_q + 1'b1;
        if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
        if (flush_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clock) begin
        if (doPush) mem_q[wrPtr_q] <= push_data_i;
    end

    assert property (@(posedge clock) disable iff (reset) !(doPush && full));

endmodule

// File: rtl/riscv_fetch_unit.sv
// Fetch front end: issues imem requests, queues responses, drains to IF/ID.
// Optional FETCH_PERF_EN adds perf_fetched / perf_dropped counters.
module riscv_fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter int              DEPTH        = 4,
    parameter logic [XLEN-1:0] RESET_PC     = 32'h0000_0000,
    parameter int              MAX_INFLIGHT = 4
) (
    input  logic            clock,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_dropped
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] fetchPc_q, fetchPc_d;
    logic [XLEN-1:0] respPc_q, respPc_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   drop_q, drop_d;
    fetch_state_e    state_q, state_d;

    logic [CW-1:0]   fifoCount, inflightLeft;
    logic [CW:0]     occupancy;
    logic            fifoEmpty, fire, rspDrop, push, pop, headValid;
    logic [XLEN-1:0] target;
    fetch_entry_t    fifoHead, pushEntry;

    assign target       = redirect_pc & ~32'h3;
    assign occupancy    = {1'b0, fifoCount} + {1'b0, inflight_q};
    assign inflightLeft = inflight_q - CW'(imem_rsp_valid);

    assign imem_req_valid = !reset && !redirect_valid
                         && (occupancy < (CW+1)'(DEPTH))
                         && (inflight_q < CW'(MAX_INFLIGHT));
    assign imem_req_addr  = fetchPc_q;
    assign fire           = imem_req_valid && imem_req_ready;

    // A response is stale if it belongs to a stream abandoned by a redirect.
    assign rspDrop   = imem_rsp_valid && (redirect_valid || state_q == DRAIN);
    assign push      = imem_rsp_valid && !rspDrop;
    assign pushEntry = '{pc: respPc_q, instr: imem_rsp_data};

    assign headValid = !reset && !fifoEmpty;
    assign pop       = headValid && if_ready && !redirect_valid;
    assign if_valid  = headValid;
    assign if_instr  = headValid ? fifoHead.instr : NOP_INSTR;
    assign if_pc     = headValid ? fifoHead.pc : '0;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .flush_i     (redirect_valid),
        .push_i      (push),
        .push_data_i (pushEntry),
        .pop_i       (pop),
        .head_o      (fifoHead),
        .count_o     (fifoCount),
        .empty_o     (fifoEmpty)
    );

    always_comb begin
        fetchPc_d  = fetchPc_q;
        respPc_d   = respPc_q;
        inflight_d = inflightLeft + CW'(fire);
        drop_d     = drop_q;
        if (redirect_valid) begin
            fetchPc_d = target;
            respPc_d  = target;
            drop_d    = inflightLeft;
        end else begin
            if (fire) fetchPc_d = fetchPc_q + 32'd4;
            if (push) respPc_d  = respPc_q + 32'd4;
            if (rspDrop && drop_q != '0) drop_d = drop_q - 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = (inflightLeft != '0) ? DRAIN : RUN;
        end else if (state_q == DRAIN && drop_d == '0) begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetchPc_q  <= RESET_PC;
            respPc_q   <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            state_q    <= RUN;
        end else begin
            fetchPc_q  <= fetchPc_d;
            respPc_q   <= respPc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            state_q    <= state_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_q, dropped_q;

    // Dropped work covers both stale responses and entries thrown out by a flush.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetched_q <= '0;
            dropped_q <= '0;
        end else begin
            fetched_q <= fetched_q + 32'(push);
            dropped_q <= dropped_q + 32'(rspDrop)
                       + (redirect_valid ? 32'(fifoCount) : 32'd0);
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_dropped = dropped_q;
`endif

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Directed self-checking bench for riscv_fetch_unit with a variable-latency memory model.
module tb_riscv_fetch_unit;

    logic        clock;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
`endif

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] gotPcQ[$];
    logic [31:0] gotInQ[$];
    int          gotCycQ[$];
    int          cyc;
    int          lat;
    int          accCount;
    int          assertCount;
    int          failCount;
    int          c0;

    riscv_fetch_unit #(
        .DEPTH        (4),
        .RESET_PC     (32'h0000_0000),
        .MAX_INFLIGHT (4)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_dropped   (perf_dropped)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic reqReady, input logic ifReady,
                                 input logic redir, input logic [31:0] redirPc);
        reset          = rst;
        imem_req_ready = reqReady;
        if_ready       = ifReady;
        redirect_valid = redir;
        redirect_pc    = redirPc;
    endtask

    function automatic logic [31:0] gotPc(input int i);
        return (i < gotPcQ.size()) ? gotPcQ[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] gotIn(input int i);
        return (i < gotInQ.size()) ? gotInQ[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic clearLog();
        gotPcQ.delete();
        gotInQ.delete();
        gotCycQ.delete();
        accCount = 0;
    endtask

    // One clock cycle: memory answers, accepted requests and deliveries are logged.
    task automatic tick();
        pend_t e;
        logic  fire;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = ~pend[0].addr;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        #1;
        fire = imem_req_valid && imem_req_ready;
        if (imem_rsp_valid) pend.pop_front();
        if (fire) begin
            e.addr = imem_req_addr;
            e.due  = cyc + lat;
            pend.push_back(e);
            accCount++;
        end
        if (if_valid && if_ready && !redirect_valid) begin
            gotPcQ.push_back(if_pc);
            gotInQ.push_back(if_instr);
            gotCycQ.push_back(cyc);
        end
        @(posedge clock);
        cyc++;
        if (reset) pend.delete();
        @(negedge clock);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        tick();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        clearLog();
    endtask

    task automatic runTicks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        assertCount    = 0;
        failCount      = 0;
        cyc            = 0;
        lat            = 1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        clearLog();
        @(negedge clock);

        // Reset values while reset is held
        tick();
        checkOutput("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
        checkOutput("rst_if_valid", {31'h0, if_valid}, 32'h0);
        checkOutput("rst_if_instr", if_instr, 32'h0000_0013);
        checkOutput("rst_if_pc", if_pc, 32'h0);
        doReset();
        #1;
        checkOutput("first_req_valid", {31'h0, imem_req_valid}, 32'h1);
        checkOutput("first_req_addr", imem_req_addr, 32'h0);

        // Zero-wait memory, pipeline always ready: one instruction per cycle
        lat = 1;
        c0  = cyc;
        runTicks(12);
        checkOutput("stream_count", gotPcQ.size(), 32'd10);
        checkOutput("stream_first_cycle", (gotCycQ.size() > 0) ? gotCycQ[0] - c0 : -1, 32'd2);
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("stream_pc%0d", i), gotPc(i), 32'(4 * i));
            checkOutput($sformatf("stream_instr%0d", i), gotIn(i), ~32'(4 * i));
        end

        // Pipeline stalled: fetch stops at DEPTH, then drains in order
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        runTicks(10);
        checkOutput("stall_accepted", accCount, 32'd4);
        checkOutput("stall_if_valid", {31'h0, if_valid}, 32'h1);
        checkOutput("stall_if_pc", if_pc, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        clearLog();
        runTicks(12);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("release_pc%0d", i), gotPc(i), 32'(4 * i));
            checkOutput($sformatf("release_instr%0d", i), gotIn(i), ~32'(4 * i));
        end

        // Redirect with three requests in flight at 3-cycle latency
        doReset();
        lat = 3;
        runTicks(3);
        checkOutput("lat3_accepted", accCount, 32'd3);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0103);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        #1;
        checkOutput("redir_req_valid", {31'h0, imem_req_valid}, 32'h1);
        checkOutput("redir_req_addr", imem_req_addr, 32'h0000_0100);
        runTicks(12);
        checkOutput("redir_pc0", gotPc(0), 32'h0000_0100);
        checkOutput("redir_instr0", gotIn(0), ~32'h0000_0100);
        checkOutput("redir_pc1", gotPc(1), 32'h0000_0104);

        // Redirect coinciding with a response and a ready pipeline
        doReset();
        lat = 1;
        runTicks(2);
        clearLog();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        #1;
        checkOutput("coinc_no_pop", gotPcQ.size(), 32'd0);
        checkOutput("coinc_fifo_empty", {31'h0, if_valid}, 32'h0);
        checkOutput("coinc_req_addr", imem_req_addr, 32'h0000_0200);
        runTicks(8);
        checkOutput("coinc_pc0", gotPc(0), 32'h0000_0200);
        checkOutput("coinc_pc1", gotPc(1), 32'h0000_0204);

        // Two redirects one cycle apart: the later target wins
        doReset();
        lat = 2;
        runTicks(4);
        clearLog();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0040);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0080);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        runTicks(12);
        checkOutput("double_pc0", gotPc(0), 32'h0000_0080);
        checkOutput("double_pc1", gotPc(1), 32'h0000_0084);
        checkOutput("double_pc2", gotPc(2), 32'h0000_0088);
        checkOutput("double_instr0", gotIn(0), ~32'h0000_0080);

        // Address wrap at the top of memory, then reset mid-burst
        doReset();
        lat = 1;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        #1;
        checkOutput("wrap_req_addr0", imem_req_addr, 32'hFFFF_FFFC);
        tick();
        checkOutput("wrap_req_addr1", imem_req_addr, 32'h0000_0000);
        runTicks(4);
        checkOutput("wrap_pc0", gotPc(0), 32'hFFFF_FFFC);
        checkOutput("wrap_pc1", gotPc(1), 32'h0000_0000);
        checkOutput("wrap_pc2", gotPc(2), 32'h0000_0004);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        checkOutput("midrst_req_valid", {31'h0, imem_req_valid}, 32'h0);
        checkOutput("midrst_if_valid", {31'h0, if_valid}, 32'h0);
        checkOutput("midrst_if_instr", if_instr, 32'h0000_0013);
        checkOutput("midrst_if_pc", if_pc, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        clearLog();
        #1;
        checkOutput("post_rst_if_valid", {31'h0, if_valid}, 32'h0);
        checkOutput("post_rst_req_valid", {31'h0, imem_req_valid}, 32'h1);
        checkOutput("post_rst_req_addr", imem_req_addr, 32'h0);
        runTicks(6);
        checkOutput("post_rst_pc0", gotPc(0), 32'h0);
        checkOutput("post_rst_pc1", gotPc(1), 32'h4);
        checkOutput("post_rst_instr1", gotIn(1), ~32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
